// File: rtl/nn_out_argmax.sv
// Per-step argmax over the RNN core's serial float output, results queued in a small FIFO.
// Optional build macro NN_ARGMAX_TIE_LAST_EN: equal keys let the later index win.
module nn_out_argmax #(
  parameter int STEPS      = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  out_idx,
  output logic [31:0] out_max,
  output logic [1:0]  out_step,
  output logic        frame_done,
  output logic        frame_err,
  output logic        ovf
);

  localparam int DATA_W = 32;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int ENT_W  = DATA_W + 4;
  localparam logic [1:0]  LAST_STEP = 2'(STEPS - 1);
  localparam logic [AW:0] DEPTH_C   = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t             state_q, state_d;
  logic [1:0]         wcnt, scnt;
  logic [DATA_W-1:0]  max_p0;
  logic [1:0]         idx_p0;
  logic               take, push, done_d, err_d;
  logic [DATA_W-1:0]  cand_max;
  logic [1:0]         cand_idx;

  // Monotonic integer key: -0 folds onto +0, negatives are bit-inverted.
  function automatic logic [DATA_W-1:0] order_key(input logic [DATA_W-1:0] w);
    logic [DATA_W-1:0] f;
    f = (w == 32'h8000_0000) ? '0 : w;
    return f[31] ? ~f : {1'b1, f[30:0]};
  endfunction

  always_comb begin
    take = 1'b0;
`ifdef NN_ARGMAX_TIE_LAST_EN
    if (order_key(in_data) >= order_key(max_p0)) take = 1'b1;
`else
    if (order_key(in_data) > order_key(max_p0)) take = 1'b1;
`endif
    if (wcnt == 2'd0) take = 1'b1;
    cand_max = take ? in_data : max_p0;
    cand_idx = take ? wcnt : idx_p0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = COLLECT;
      COLLECT: begin
        if (!in_valid)                                   state_d = IDLE;
        else if (wcnt == 2'd2 && scnt == LAST_STEP)      state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    push   = 1'b0;
    done_d = 1'b0;
    err_d  = 1'b0;
    if (state_q == COLLECT) begin
      push   = in_valid && (wcnt == 2'd2);
      done_d = push && (scnt == LAST_STEP);
      err_d  = !in_valid;
    end
  end

  // Stage p0: word/step counters and completion pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt       <= '0;
      scnt       <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_done <= done_d;
      frame_err  <= err_d;
      if (!in_valid) begin
        wcnt <= '0;
        scnt <= '0;
      end else if (wcnt == 2'd2) begin
        wcnt <= '0;
        scnt <= (scnt == LAST_STEP) ? 2'd0 : scnt + 2'd1;
      end else begin
        wcnt <= wcnt + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid) begin
      max_p0 <= cand_max;
      idx_p0 <= cand_idx;
    end
  end

  logic [ENT_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             full, pop, wr_en;
  logic [ENT_W-1:0] head;

  assign full      = (count == DEPTH_C);
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign wr_en     = push && (!full || pop);
  assign head      = mem[rd_ptr];

  // Stage p1: result FIFO; a full queue with a concurrent pop still accepts the push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      if (wr_en && !pop)      count <= count + (AW + 1)'(1);
      else if (!wr_en && pop) count <= count - (AW + 1)'(1);
      if (push && full && !pop) ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {cand_idx, scnt, cand_max};
  end

  always_comb begin
    out_idx  = '0;
    out_step = '0;
    out_max  = '0;
    if (out_valid) begin
      out_idx  = head[ENT_W-1 -: 2];
      out_step = head[ENT_W-3 -: 2];
      out_max  = head[DATA_W-1:0];
    end
  end

endmodule
